registro_banco: RTL

- Parametrised register bank: DEPTH entries of WIDTH bits, flop-based.
- Successor of the single-bit read/write register cell.
- Single shared port: read_write selects write (1) or read (0) on each request; reads have 1-cycle registered latency with a valid strobe.
- Built-in sequential clear engine sweeps all entries to zero on request; reports busy while sweeping.

---
 rtl/registro_pkg.sv | 16 +
 rtl/registro_cella.sv | 38 +++
 rtl/registro_banco.sv | 126 ++++++++++++
 3 files changed

// File: rtl/registro_pkg.sv
// Shared types and constants for the registro_banco register bank.
// The optional swap-on-write feature is selected by REGISTRO_BANCO_WRBACK_EN.
package registro_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 16;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/registro_cella.sv
// One WIDTH-bit storage entry: write enable, synchronous clear, synchronous active-low reset.
// Clear wins over write so the sweep engine always leaves the entry at zero.
module registro_cella
    import registro_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             we,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (clr) begin
            q_d = '0;
        end else if (we) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/registro_banco.sv
// Flop-based register bank with one shared read/write port and a sequential clear sweep.
// Define REGISTRO_BANCO_WRBACK_EN to make writes also return the old entry contents.
module registro_banco
    import registro_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic             read_write,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] data_out,
    output logic             data_out_valid,
    output logic             addr_err,
    input  logic             clear,
    output logic             busy
);

`ifdef REGISTRO_BANCO_WRBACK_EN
    localparam logic WRBACK = 1'b1;
`else
    localparam logic WRBACK = 1'b0;
`endif

    localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             valid_q, valid_d;
    logic             addr_err_q, addr_err_d;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] we_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [WIDTH-1:0] rd_word;
    logic             in_range;
    logic             accept;
    logic             wr_en;
    logic             rd_fire;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_cell
            assign we_vec[gi]  = wr_en && (addr == AW'(gi));
            assign clr_vec[gi] = (state_q == CLEAR) && (cnt_q == AW'(gi));

            registro_cella #(.WIDTH(WIDTH)) u_cella (
                .clk     (clk),
                .reset_n (reset_n),
                .we      (we_vec[gi]),
                .clr     (clr_vec[gi]),
                .d       (data),
                .q       (mem[gi])
            );
        end
    endgenerate

    always_comb begin
        // Out-of-range addresses match no entry, so they read back as zero.
        rd_word = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr == AW'(i)) begin
                rd_word = mem[i];
            end
        end

        in_range = ({1'b0, addr} < DEPTH_W);
        accept   = (state_q == IDLE) && !clear && req;
        wr_en    = accept && (read_write == RW_WRITE) && in_range;
        rd_fire  = accept && ((read_write == RW_READ) || WRBACK);

        valid_d    = rd_fire;
        data_out_d = rd_fire ? rd_word : data_out_q;
        addr_err_d = accept && !in_range;

        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            data_out_q <= '0;
            valid_q    <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign data_out       = data_out_q;
    assign data_out_valid = valid_q;
    assign addr_err       = addr_err_q;
    assign busy           = (state_q == CLEAR);

endmodule
